// File: rtl/key_conditioner.sv
// key_conditioner: per-key synchroniser, tick-qualified debounce and press/release/event pulses.
// Define KEY_CONDITIONER_AUTO_REPEAT_EN to build the per-channel auto-repeat on key_event.
module key_conditioner #(
    parameter int unsigned N_KEYS       = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned TICK_DIV     = 100,
    parameter int unsigned STABLE_TICKS = 4,
    parameter int unsigned REPEAT_DELAY = 50,
    parameter int unsigned REPEAT_RATE  = 10
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [N_KEYS-1:0] key_in,
    input  logic [N_KEYS-1:0] repeat_mask,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_event
);

    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned SW = $clog2(STABLE_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q [N_KEYS];
    logic [N_KEYS-1:0]      key_s;
    logic [TW-1:0]          tick_cnt;
    logic                   tick;
    logic [SW-1:0]          stable_q [N_KEYS];
    logic [SW-1:0]          stable_d [N_KEYS];
    logic [N_KEYS-1:0]      level_d;
    logic [N_KEYS-1:0]      press_d;
    logic [N_KEYS-1:0]      release_d;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int unsigned k = 0; k < N_KEYS; k++) sync_q[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < N_KEYS; k++)
                sync_q[k] <= {sync_q[k][SYNC_STAGES-2:0], key_in[k]};
        end
    end

    always_comb begin
        key_s = '0;
        for (int unsigned k = 0; k < N_KEYS; k++) key_s[k] = sync_q[k][SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr)                   tick_cnt <= '0;
        else if (tick_cnt == TICK_LAST) tick_cnt <= '0;
        else                       tick_cnt <= tick_cnt + 1'b1;
    end

    assign tick = (tick_cnt == TICK_LAST);

    // A new level is accepted on the tick whose differing sample would make the count terminal.
    always_comb begin
        level_d   = key_level;
        press_d   = '0;
        release_d = '0;
        for (int unsigned k = 0; k < N_KEYS; k++) begin
            stable_d[k] = stable_q[k];
            if (tick) begin
                if (key_s[k] != key_level[k]) begin
                    if (stable_q[k] == STABLE_LAST) begin
                        level_d[k]   = key_s[k];
                        stable_d[k]  = '0;
                        press_d[k]   = key_s[k];
                        release_d[k] = ~key_s[k];
                    end else begin
                        stable_d[k] = stable_q[k] + 1'b1;
                    end
                end else begin
                    stable_d[k] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            key_level   <= '0;
            key_press   <= '0;
            key_release <= '0;
            for (int unsigned k = 0; k < N_KEYS; k++) stable_q[k] <= '0;
        end else begin
            key_level   <= level_d;
            key_press   <= press_d;
            key_release <= release_d;
            for (int unsigned k = 0; k < N_KEYS; k++) stable_q[k] <= stable_d[k];
        end
    end

`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
    typedef enum logic [1:0] {RPT_IDLE, RPT_HELD, RPT_REPEAT} rpt_state_e;

    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW      = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    rpt_state_e        rpt_state_q [N_KEYS];
    rpt_state_e        rpt_state_d [N_KEYS];
    logic [RW-1:0]     rpt_cnt_q   [N_KEYS];
    logic [RW-1:0]     rpt_cnt_d   [N_KEYS];
    logic [N_KEYS-1:0] rpt_fire;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int unsigned k = 0; k < N_KEYS; k++) begin
                rpt_state_q[k] <= RPT_IDLE;
                rpt_cnt_q[k]   <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < N_KEYS; k++) begin
                rpt_state_q[k] <= rpt_state_d[k];
                rpt_cnt_q[k]   <= rpt_cnt_d[k];
            end
        end
    end

    // Release outranks everything; a masked tick parks the channel in HELD with a cleared count.
    always_comb begin
        rpt_fire = '0;
        for (int unsigned k = 0; k < N_KEYS; k++) begin
            rpt_state_d[k] = rpt_state_q[k];
            rpt_cnt_d[k]   = rpt_cnt_q[k];
            if (release_d[k]) begin
                rpt_state_d[k] = RPT_IDLE;
                rpt_cnt_d[k]   = '0;
            end else if (press_d[k]) begin
                rpt_state_d[k] = RPT_HELD;
                rpt_cnt_d[k]   = '0;
            end else if (tick && rpt_state_q[k] != RPT_IDLE) begin
                if (!repeat_mask[k]) begin
                    rpt_state_d[k] = RPT_HELD;
                    rpt_cnt_d[k]   = '0;
                end else if (rpt_state_q[k] == RPT_HELD) begin
                    if (rpt_cnt_q[k] == DELAY_LAST) begin
                        rpt_fire[k]    = 1'b1;
                        rpt_cnt_d[k]   = '0;
                        rpt_state_d[k] = RPT_REPEAT;
                    end else begin
                        rpt_cnt_d[k] = rpt_cnt_q[k] + 1'b1;
                    end
                end else begin
                    if (rpt_cnt_q[k] == RATE_LAST) begin
                        rpt_fire[k]  = 1'b1;
                        rpt_cnt_d[k] = '0;
                    end else begin
                        rpt_cnt_d[k] = rpt_cnt_q[k] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) key_event <= '0;
        else     key_event <= press_d | rpt_fire;
    end
`else
    logic unused_repeat_mask;
    assign unused_repeat_mask = ^repeat_mask;
    assign key_event = key_press;
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: tick-level reference model feeds an expected-pulse queue.
module tb_key_conditioner;

    localparam int NK     = 4;
    localparam int SYNC   = 2;
    localparam int TDIV   = 4;
    localparam int STABLE = 3;
    localparam int RDELAY = 5;
    localparam int RRATE  = 2;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic [NK-1:0] key_in = '0;
    logic [NK-1:0] repeat_mask = '0;
    logic [NK-1:0] key_level, key_press, key_release, key_event;

    key_conditioner #(
        .N_KEYS(NK), .SYNC_STAGES(SYNC), .TICK_DIV(TDIV),
        .STABLE_TICKS(STABLE), .REPEAT_DELAY(RDELAY), .REPEAT_RATE(RRATE)
    ) dut (
        .clk(clk), .clr(clr), .key_in(key_in), .repeat_mask(repeat_mask),
        .key_level(key_level), .key_press(key_press),
        .key_release(key_release), .key_event(key_event)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [NK-1:0] lvl, prs, rel, evt;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    logic [NK-1:0] hq[$];
    int            cyc = 0;
    int            ecount = 0;
    logic          m_tick = 1'b0;
    logic [NK-1:0] m_level = '0;
    int            m_run  [NK];
    int            m_held [NK];
    int            m_press_cnt [NK];

    // Observed DUT pulse counters
    int d_press_cnt [NK];
    int d_rel_cnt   [NK];
    int d_evt_cnt   [NK];
    int d_press_all = 0;

    initial begin
        for (int i = 0; i < NK; i++) begin
            m_run[i] = 0; m_held[i] = 0; m_press_cnt[i] = 0;
            d_press_cnt[i] = 0; d_rel_cnt[i] = 0; d_evt_cnt[i] = 0;
        end
    end

    always @(posedge clk) begin : model_p
        logic [NK-1:0] s, prs, rel, evt;
        cyc++;
        prs = '0; rel = '0; evt = '0;
        if (clr) begin
            hq = {};
            for (int i = 0; i < SYNC; i++) hq.push_back('0);
            ecount  = 0;
            m_tick  = 1'b0;
            m_level = '0;
            for (int i = 0; i < NK; i++) begin m_run[i] = 0; m_held[i] = 0; end
        end else begin
            s = hq[0];
            hq.push_back(key_in);
            void'(hq.pop_front());
            m_tick = ((ecount % TDIV) == TDIV - 1);
            ecount++;
            if (m_tick) begin
                for (int k = 0; k < NK; k++) begin
                    if (s[k] != m_level[k]) begin
                        m_run[k]++;
                        if (m_run[k] == STABLE) begin
                            m_level[k] = s[k];
                            m_run[k]   = 0;
                            if (s[k]) begin prs[k] = 1'b1; m_press_cnt[k]++; end
                            else      rel[k] = 1'b1;
                        end
                    end else begin
                        m_run[k] = 0;
                    end
`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
                    if (prs[k]) begin
                        evt[k]    = 1'b1;
                        m_held[k] = 0;
                    end else if (m_level[k]) begin
                        if (repeat_mask[k]) begin
                            m_held[k]++;
                            if (m_held[k] == RDELAY ||
                                (m_held[k] > RDELAY && ((m_held[k] - RDELAY) % RRATE) == 0))
                                evt[k] = 1'b1;
                        end else begin
                            m_held[k] = 0;
                        end
                    end
`else
                    evt[k] = prs[k];
`endif
                end
            end
            if ((prs | rel | evt) != '0) sbq.push_back('{cyc, m_level, prs, rel, evt});
        end
    end

    always @(negedge clk) begin : monitor_p
        exp_t e;
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            e = sbq.pop_front();
            n_checks++; n_fail++;
            $display("FAIL missed_pulse: cycle %0d expected press=%h release=%h event=%h, DUT outputs stayed low",
                     e.cyc, e.prs, e.rel, e.evt);
        end
        if (!clr && (key_press | key_release | key_event) != '0) begin
            n_checks++;
            for (int k = 0; k < NK; k++) begin
                if (key_press[k])   d_press_cnt[k]++;
                if (key_release[k]) d_rel_cnt[k]++;
                if (key_event[k])   d_evt_cnt[k]++;
            end
            if (key_press == '1) d_press_all++;
            if (sbq.size() == 0 || sbq[0].cyc != cyc) begin
                n_fail++;
                $display("FAIL spurious_pulse: cycle %0d got level=%h press=%h release=%h event=%h, expected no pulse",
                         cyc, key_level, key_press, key_release, key_event);
            end else begin
                e = sbq.pop_front();
                if (key_level !== e.lvl || key_press !== e.prs ||
                    key_release !== e.rel || key_event !== e.evt) begin
                    n_fail++;
                    $display("FAIL pulse_vector: cycle %0d got l=%h p=%h r=%h e=%h expected l=%h p=%h r=%h e=%h",
                             cyc, key_level, key_press, key_release, key_event,
                             e.lvl, e.prs, e.rel, e.evt);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_ticks(input int n);
        int seen = 0;
        while (seen < n) begin
            step();
            if (m_tick) seen++;
        end
    endtask

    task automatic wait_model_press(input int ch, input int budget, input string name);
        int base = m_press_cnt[ch];
        int c = 0;
        while (m_press_cnt[ch] == base && c < budget) begin
            step();
            c++;
        end
        if (m_press_cnt[ch] == base) begin
            n_checks++; n_fail++;
            $display("FAIL %s: no press within %0d cycles", name, budget);
        end
    endtask

    // Hold key ch from press through 15 more ticks, then release; returns DUT events seen.
    task automatic hold_test(input int ch, input string name, output int evts);
        int base = d_evt_cnt[ch];
        key_in[ch] = 1'b1;
        wait_model_press(ch, 60, name);
        wait_ticks(15);
        key_in[ch] = 1'b0;
        repeat (40) step();
        evts = d_evt_cnt[ch] - base;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int evts, base;
        repeat (3) step();
        clr = 1'b0;
        step();
        check("reset_level",   int'(key_level),   0);
        check("reset_press",   int'(key_press),   0);
        check("reset_release", int'(key_release), 0);
        check("reset_event",   int'(key_event),   0);

        // Short glitch: only two qualifying samples
        key_in[0] = 1'b1;
        repeat (8) step();
        key_in[0] = 1'b0;
        repeat (30) step();
        check("glitch_press0", d_press_cnt[0], 0);
        check("glitch_event0", d_evt_cnt[0], 0);
        check("glitch_level0", int'(key_level[0]), 0);

        // Steady press then release
        key_in[1] = 1'b1;
        wait_model_press(1, 60, "press1_wait");
        repeat (2) step();
        check("press1_count", d_press_cnt[1], 1);
        check("press1_level", int'(key_level[1]), 1);
        key_in[1] = 1'b0;
        repeat (30) step();
        check("release1_count", d_rel_cnt[1], 1);
        check("release1_level", int'(key_level[1]), 0);

        // All keys together
        key_in = 4'hF;
        repeat (25) step();
        check("allpress_cycles", d_press_all, 1);
        check("allpress_ch0", d_press_cnt[0], 1);
        check("allpress_ch3", d_press_cnt[3], 1);
        check("allpress_level", int'(key_level), 'hF);
        key_in = '0;
        repeat (30) step();

        // Auto-repeat allowed on channel 2
        repeat_mask = 4'h4;
        hold_test(2, "repeat_on_wait", evts);
`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
        check("repeat_on_events", evts, 8);
`else
        check("repeat_on_events", evts, 1);
`endif
        repeat_mask = 4'h0;
        hold_test(2, "repeat_off_wait", evts);
        check("repeat_off_events", evts, 1);

        // Reset while key 3 held
        repeat_mask = 4'hF;
        key_in[3] = 1'b1;
        wait_model_press(3, 60, "clr_press_wait");
        wait_ticks(10);
        clr = 1'b1;
        #1;
        check("clr_async_level", int'(key_level),   0);
        check("clr_async_press", int'(key_press),   0);
        check("clr_async_rel",   int'(key_release), 0);
        check("clr_async_event", int'(key_event),   0);
        step(); step();
        base = d_press_cnt[3];
        clr = 1'b0;
        wait_model_press(3, 60, "clr_repress_wait");
        repeat (2) step();
        check("clr_repress_count", d_press_cnt[3] - base, 1);
        check("clr_repress_level", int'(key_level[3]), 1);
        key_in = '0;
        repeat (40) step();

        // Randomised traffic
        for (int it = 0; it < 40; it++) begin
            key_in      = key_in ^ 4'($urandom_range(0, 15));
            repeat_mask = 4'($urandom);
            repeat ($urandom_range(1, 30)) step();
        end
        key_in = '0;
        repeat_mask = '0;
        repeat (40) step();
        check("final_level", int'(key_level), int'(m_level));
        check("final_queue_empty", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
